lv_rdgen: RTL and testbench

//  Parametrised pseudo-random word generator for ECC core simulation/bring-up (NOT a TRNG).

---
 rtl/lv_rd_pkg.sv | 22 ++
 rtl/lv_rdstep.sv | 22 ++
 rtl/lv_rdgen.sv | 88 ++++++++
 tb/tb_lv_rdgen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lv_rd_pkg.sv
// Shared constants for the lv_rdgen pseudo-random word generator:
// FSM state codes and the default Galois masks and seeds.
package lv_rd_pkg;

    localparam logic [0:0] ST_WARM = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Bits 255/253/250/245 set.
    localparam logic [255:0] TAPS_256 = {1'b1, 1'b0, 1'b1, 2'b0, 1'b1, 4'b0, 1'b1, 245'b0};
    localparam logic [255:0] SEED_256 =
        256'd1347997333231989955025617139070862921545325381669592728147103286558;

    // Small configuration for bring-up benches.
    localparam logic [7:0] TAPS_8 = 8'hB8;
    localparam logic [7:0] SEED_8 = 8'h01;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lv_rdstep.sv
// STEPS chained Galois LFSR steps, purely combinational.
// A step shifts right and folds the mask in when the bit shifted out was set.
module lv_rdstep #(
    parameter int               WID   = 256,
    parameter logic [WID-1:0]   TAPS  = '0,
    parameter int               STEPS = 1
) (
    input  logic [WID-1:0] cur,
    output logic [WID-1:0] nxt
);

    logic [WID-1:0] v;

    always_comb begin
        v = cur;
        for (int i = 0; i < STEPS; i++) begin
            v = (v >> 1) ^ (v[0] ? TAPS : '0);
        end
        nxt = v;
    end

endmodule

// File: rtl/lv_rdgen.sv
// Pseudo-random word generator for ECC bring-up: Galois LFSR with seed load,
// warm-up discard and a valid/ready output stream.  Not a TRNG.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_WARM | discarding WARMUP advances after reset/seed, busy=1, rd_vld=0
//  ST_RUN  | word presented on rd_dat, advance on each accepted handshake
module lv_rdgen
    import lv_rd_pkg::*;
#(
    parameter int               WID    = 256,
    parameter logic [WID-1:0]   TAPS   = TAPS_256[WID-1:0],
    parameter logic [WID-1:0]   SEED   = SEED_256[WID-1:0],
    parameter int               OWID   = 256,
    parameter int               STEPS  = 1,
    parameter int               WARMUP = 16,
    parameter int               CNTW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            seed_ld,
    input  logic [WID-1:0]  seed_in,
    output logic            rd_vld,
    input  logic            rd_rdy,
    output logic [OWID-1:0] rd_dat,
    output logic            busy,
    output logic            zseed_err,
    output logic [CNTW-1:0] word_cnt
);

    localparam int WCW = cnt_width(WARMUP);

    logic [0:0]     fsm;
    logic [WID-1:0] state;
    logic [WID-1:0] state_adv;
    logic [WID-1:0] seed_nxt;
    logic           seed_zero;
    logic [WCW-1:0] warm_cnt;

    lv_rdstep #(
        .WID   (WID),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_step (
        .cur (state),
        .nxt (state_adv)
    );

    // A zero seed would lock the LFSR at zero, so fall back to SEED.
    assign seed_zero = (seed_in == '0);
    assign seed_nxt  = seed_zero ? SEED : seed_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SEED;
            fsm       <= ST_WARM;
            warm_cnt  <= '0;
            word_cnt  <= '0;
            zseed_err <= 1'b0;
        end else if (seed_ld) begin
            state    <= seed_nxt;
            fsm      <= ST_WARM;
            warm_cnt <= '0;
            word_cnt <= '0;
            if (seed_zero) begin
                zseed_err <= 1'b1;
            end
        end else if (fsm == ST_WARM) begin
            if (WARMUP == 0) begin
                fsm <= ST_RUN;
            end else begin
                state    <= state_adv;
                warm_cnt <= warm_cnt + WCW'(1);
                if (warm_cnt == WCW'(WARMUP - 1)) begin
                    fsm <= ST_RUN;
                end
            end
        end else if (rd_rdy) begin
            state    <= state_adv;
            word_cnt <= word_cnt + CNTW'(1);
        end
    end

    assign rd_vld = (fsm == ST_RUN);
    assign busy   = (fsm == ST_WARM);
    assign rd_dat = state[OWID-1:0];

endmodule

// File: tb/tb_lv_rdgen.sv
// Bench for lv_rdgen: four configurations (8-bit WARMUP=0, WARMUP=4, STEPS=2,
// default 256-bit) checked against an arithmetic LFSR reference.
module tb_lv_rdgen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] REF_TAPS = (256'd1 << 255) | (256'd1 << 253) |
                                        (256'd1 << 250) | (256'd1 << 245);
    localparam logic [255:0] REF_SEED =
        256'd1347997333231989955025617139070862921545325381669592728147103286558;

    // instance A: WID=8, WARMUP=0, STEPS=1
    logic a_ld = 0, a_rdy = 0, a_vld, a_busy, a_zerr;
    logic [7:0] a_sin = 0, a_dat;
    logic [31:0] a_cnt;
    // instance B: WARMUP=4
    logic b_ld = 0, b_rdy = 0, b_vld, b_busy, b_zerr;
    logic [7:0] b_sin = 0, b_dat;
    logic [31:0] b_cnt;
    // instance C: STEPS=2
    logic c_ld = 0, c_rdy = 0, c_vld, c_busy, c_zerr;
    logic [7:0] c_sin = 0, c_dat;
    logic [31:0] c_cnt;
    // instance D: default 256-bit
    logic d_ld = 0, d_rdy = 0, d_vld, d_busy, d_zerr;
    logic [255:0] d_sin = '0, d_dat;
    logic [31:0] d_cnt;

    lv_rdgen #(.WID(8), .TAPS(8'hB8), .SEED(8'h01), .OWID(8), .STEPS(1), .WARMUP(0), .CNTW(32))
    u_a (.clk(clk), .rst(rst), .seed_ld(a_ld), .seed_in(a_sin), .rd_vld(a_vld), .rd_rdy(a_rdy),
         .rd_dat(a_dat), .busy(a_busy), .zseed_err(a_zerr), .word_cnt(a_cnt));

    lv_rdgen #(.WID(8), .TAPS(8'hB8), .SEED(8'h01), .OWID(8), .STEPS(1), .WARMUP(4), .CNTW(32))
    u_b (.clk(clk), .rst(rst), .seed_ld(b_ld), .seed_in(b_sin), .rd_vld(b_vld), .rd_rdy(b_rdy),
         .rd_dat(b_dat), .busy(b_busy), .zseed_err(b_zerr), .word_cnt(b_cnt));

    lv_rdgen #(.WID(8), .TAPS(8'hB8), .SEED(8'h01), .OWID(8), .STEPS(2), .WARMUP(0), .CNTW(32))
    u_c (.clk(clk), .rst(rst), .seed_ld(c_ld), .seed_in(c_sin), .rd_vld(c_vld), .rd_rdy(c_rdy),
         .rd_dat(c_dat), .busy(c_busy), .zseed_err(c_zerr), .word_cnt(c_cnt));

    lv_rdgen u_d (.clk(clk), .rst(rst), .seed_ld(d_ld), .seed_in(d_sin), .rd_vld(d_vld),
                  .rd_rdy(d_rdy), .rd_dat(d_dat), .busy(d_busy), .zseed_err(d_zerr),
                  .word_cnt(d_cnt));

    function automatic logic [7:0] ref8(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [255:0] ref256(input logic [255:0] s);
        return (s >> 1) ^ (s[0] ? REF_TAPS : 256'd0);
    endfunction

    // Reference for instance A: current word, whether a word is on offer,
    // words delivered since seeding, sticky zero-seed flag.
    logic [7:0]  m_word;
    logic        m_avail;
    logic [31:0] m_cnt;
    logic        m_zerr;

    task automatic model_a_reset;
        m_word = 8'h01; m_avail = 0; m_cnt = 0; m_zerr = 0;
    endtask

    // Apply one cycle of inputs to A at a negedge, predict, then check at the next negedge.
    task automatic step_a(input logic ld, input logic [7:0] sin, input logic rdy);
        a_ld = ld; a_sin = sin; a_rdy = rdy;
        if (ld) begin
            m_word = (sin == 8'h00) ? 8'h01 : sin;
            if (sin == 8'h00) m_zerr = 1;
            m_avail = 0; m_cnt = 0;
        end else if (!m_avail) begin
            m_avail = 1;
        end else if (rdy) begin
            m_word = ref8(m_word);
            m_cnt = m_cnt + 1;
        end
        @(negedge clk);
        a_ld = 0;
        checks++; if (a_vld !== m_avail) begin errors++; $display("FAIL a_vld got %0b exp %0b t=%0t", a_vld, m_avail, $time); end
        checks++; if (a_busy !== !m_avail) begin errors++; $display("FAIL a_busy got %0b exp %0b t=%0t", a_busy, !m_avail, $time); end
        checks++; if (a_dat !== m_word) begin errors++; $display("FAIL a_dat got %h exp %h t=%0t", a_dat, m_word, $time); end
        checks++; if (a_cnt !== m_cnt) begin errors++; $display("FAIL a_cnt got %0d exp %0d t=%0t", a_cnt, m_cnt, $time); end
        checks++; if (a_zerr !== m_zerr) begin errors++; $display("FAIL a_zerr got %0b exp %0b t=%0t", a_zerr, m_zerr, $time); end
    endtask

    task automatic test_reset;
        rst = 0;
        @(negedge clk); @(negedge clk);
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", a_vld); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b exp 1", a_busy); end
        checks++; if (a_dat !== 8'h01) begin errors++; $display("FAIL reset_dat got %h exp 01", a_dat); end
        checks++; if (a_cnt !== 32'd0 || a_zerr !== 1'b0) begin errors++; $display("FAIL reset_cnt_zerr got %0d/%0b exp 0/0", a_cnt, a_zerr); end
        checks++; if (d_dat !== REF_SEED || d_busy !== 1'b1) begin errors++; $display("FAIL reset_wide got busy %0b exp 1", d_busy); end
        rst = 1;
        model_a_reset();
    endtask

    task automatic test_sequence;
        logic [7:0] exp_seq [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        for (int i = 0; i < 6; i++) begin
            step_a(0, 8'h00, 1);
            checks++;
            if (a_dat !== exp_seq[i]) begin errors++; $display("FAIL seq[%0d] got %h exp %h", i, a_dat, exp_seq[i]); end
        end
        a_rdy = 0;
    endtask

    task automatic test_period;
        bit seen [256];
        logic [7:0] first;
        int dups = 0;
        int zeros = 0;
        step_a(1, 8'h01, 1);
        step_a(0, 8'h00, 1);
        first = a_dat;
        for (int i = 0; i < 256; i++) seen[i] = 0;
        for (int i = 0; i < 255; i++) begin
            if (a_dat == 8'h00) zeros++;
            if (seen[a_dat]) dups++;
            seen[a_dat] = 1;
            step_a(0, 8'h00, 1);
        end
        checks++; if (zeros != 0 || dups != 0) begin errors++; $display("FAIL period_unique got zeros %0d dups %0d exp 0 0", zeros, dups); end
        checks++; if (a_dat !== first) begin errors++; $display("FAIL period_wrap got %h exp %h", a_dat, first); end
        checks++; if (a_cnt !== 32'd255) begin errors++; $display("FAIL period_cnt got %0d exp 255", a_cnt); end
        a_rdy = 0;
    endtask

    task automatic test_toggle;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 15) == 0)
                step_a(1, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
            else
                step_a(0, 8'h00, 1'(i % 2));
        end
        for (int i = 0; i < 40; i++) step_a(0, 8'h00, 1'($urandom_range(0, 1)));
        a_rdy = 0;
    endtask

    task automatic test_zero_seed;
        step_a(0, 8'h00, 1);
        step_a(0, 8'h00, 1);
        step_a(1, 8'h00, 1);
        checks++; if (a_zerr !== 1'b1 || a_dat !== 8'h01 || a_busy !== 1'b1) begin
            errors++; $display("FAIL zseed got zerr %0b dat %h busy %0b exp 1 01 1", a_zerr, a_dat, a_busy); end
        step_a(0, 8'h00, 1);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL zseed_busy_len got %0b exp 0", a_busy); end
        step_a(1, 8'h5A, 0);
        step_a(0, 8'h00, 1);
        step_a(0, 8'h00, 1);
        a_rdy = 0;
    endtask

    task automatic test_warmup;
        int busy_n = 0;
        logic [7:0] e;
        b_ld = 1; b_sin = 8'h01; b_rdy = 1;
        @(negedge clk);
        b_ld = 0;
        for (int i = 0; i < 20 && !b_vld; i++) begin
            if (b_busy) busy_n++;
            @(negedge clk);
        end
        checks++; if (b_vld !== 1'b1) begin errors++; $display("FAIL warm_timeout got vld %0b exp 1", b_vld); end
        checks++; if (busy_n != 4) begin errors++; $display("FAIL warm_busy got %0d exp 4", busy_n); end
        checks++; if (b_dat !== 8'h17 || b_cnt !== 32'd0) begin errors++; $display("FAIL warm_first got %h/%0d exp 17/0", b_dat, b_cnt); end
        e = 8'h17;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            e = ref8(e);
            checks++; if (b_dat !== e || b_cnt !== 32'(k)) begin errors++; $display("FAIL warm_word%0d got %h/%0d exp %h/%0d", k, b_dat, b_cnt, e, k); end
        end
        b_rdy = 0;
    endtask

    task automatic test_steps2;
        logic [7:0] exp_seq [3] = '{8'h01, 8'h5C, 8'h17};
        c_ld = 1; c_sin = 8'h01; c_rdy = 1;
        @(negedge clk);
        c_ld = 0;
        checks++; if (c_busy !== 1'b1 || c_vld !== 1'b0) begin errors++; $display("FAIL steps2_warm got busy %0b vld %0b exp 1 0", c_busy, c_vld); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (c_vld !== 1'b1 || c_dat !== exp_seq[i]) begin errors++; $display("FAIL steps2[%0d] got %h exp %h", i, c_dat, exp_seq[i]); end
        end
        c_rdy = 0;
    endtask

    task automatic test_wide;
        logic [255:0] m;
        logic [255:0] sd;
        int busy_n = 0;
        m = REF_SEED;
        for (int i = 0; i < 16; i++) m = ref256(m);
        checks++; if (d_vld !== 1'b1 || d_dat !== m) begin errors++; $display("FAIL wide_post_reset got vld %0b exp 1 (word mismatch %0b)", d_vld, d_dat !== m); end
        d_rdy = 1;
        repeat (3) @(negedge clk);
        checks++; if (d_cnt !== 32'd3) begin errors++; $display("FAIL wide_pre_cnt got %0d exp 3", d_cnt); end
        for (int i = 0; i < 8; i++) sd[i*32 +: 32] = $urandom;
        sd[0] = 1'b1;
        d_ld = 1; d_sin = sd;
        @(negedge clk);
        d_ld = 0;
        checks++; if (d_cnt !== 32'd0 || d_busy !== 1'b1) begin errors++; $display("FAIL wide_ld_beats_hs got cnt %0d busy %0b exp 0 1", d_cnt, d_busy); end
        for (int i = 0; i < 40 && !d_vld; i++) begin
            if (d_busy) busy_n++;
            @(negedge clk);
        end
        checks++; if (d_vld !== 1'b1 || busy_n != 16) begin errors++; $display("FAIL wide_warm got vld %0b busy %0d exp 1 16", d_vld, busy_n); end
        m = sd;
        for (int i = 0; i < 16; i++) m = ref256(m);
        for (int k = 0; k < 1000; k++) begin
            checks++; if (d_dat !== m || d_cnt !== 32'(k)) begin errors++; $display("FAIL wide_word%0d got cnt %0d exp %0d", k, d_cnt, k); end
            @(negedge clk);
            m = ref256(m);
        end
        checks++; if (d_cnt !== 32'd1000) begin errors++; $display("FAIL wide_cnt got %0d exp 1000", d_cnt); end
        d_rdy = 0;
    endtask

    task automatic test_midreset;
        step_a(0, 8'h00, 1);
        step_a(0, 8'h00, 1);
        #3 rst = 0;
        #1;
        checks++; if (a_vld !== 1'b0 || a_busy !== 1'b1) begin errors++; $display("FAIL midrst_flags got vld %0b busy %0b exp 0 1", a_vld, a_busy); end
        checks++; if (a_dat !== 8'h01 || a_cnt !== 32'd0 || a_zerr !== 1'b0) begin
            errors++; $display("FAIL midrst_state got %h/%0d/%0b exp 01/0/0", a_dat, a_cnt, a_zerr); end
        @(negedge clk);
        rst = 1;
        model_a_reset();
        step_a(0, 8'h00, 1);
        step_a(0, 8'h00, 1);
        a_rdy = 0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_period();
        test_toggle();
        test_zero_seed();
        test_warmup();
        test_steps2();
        test_wide();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
